// File: rtl/mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp
// Purpose  : Single-port word RAM behind a four-phase request/ready
//            handshake. Each request is held in a programmable wait state
//            before the access completes. Illegal requests still complete,
//            but they flag err and leave the RAM untouched.
// Ports    : clk    - clock; all state changes on the rising edge
//            rst    - synchronous active-high reset
//            mem_rd - read request, held by the initiator until ready
//            mem_wr - write request, held by the initiator until ready
//            addr   - 16-bit word address
//            wdata  - 32-bit write data, captured with the request
//            rdata  - 32-bit read data, held until the next completed access
//            ready  - one-cycle completion pulse
//            err    - access fault, qualified by ready
//            busy   - high whenever the controller is not idle
// Revision : 1.0 - initial release
// ============================================================================
module mem_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int         c_DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              w_accept;
    logic              w_access;
    logic              w_oob;

    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_is_wr;
    logic              r_fault;
    logic [31:0]       r_rdata;

    logic [31:0]       r_mem [0:c_DEPTH-1];

    // Address bits above the RAM range make the access a fault. With a full
    // 16-bit RAM there are no such bits.
    generate
        if (ADDR_W < 16) begin : g_oob
            assign w_oob = |addr[15:ADDR_W];
        end else begin : g_no_oob
            assign w_oob = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (mem_rd || mem_wr) begin
                    w_accept     = 1'b1;
                    w_next_state = c_WAIT;
                end
            end
            c_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_next_state = c_RESP;
                end
            end
            c_RESP: begin
                w_next_state = c_DONE;
            end
            c_DONE: begin
                // A request still held here belongs to the access that has
                // just completed. Wait for it to drop before going idle.
                if (!mem_rd && !mem_wr) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter and read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_is_wr <= 1'b0;
            r_fault <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            if (w_accept) begin
                // The request is captured here. Later changes on the
                // request inputs do not affect the access in flight.
                r_addr  <= addr[ADDR_W-1:0];
                r_wdata <= wdata;
                r_is_wr <= mem_wr;
                r_fault <= (mem_rd && mem_wr) || w_oob;
                r_cnt   <= c_WAIT_LOAD;
            end else if ((r_state == c_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                if (r_fault) begin
                    r_rdata <= 32'h0;
                end else if (!r_is_wr) begin
                    r_rdata <= r_mem[r_addr];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM write port. The RAM has no reset. Reset still blocks the write so
    // that an access aborted by reset at its access edge leaves the RAM
    // unchanged.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_access && r_is_wr && !r_fault) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign rdata = r_rdata;
    assign ready = (r_state == c_RESP);
    assign err   = (r_state == c_RESP) && r_fault;
    assign busy  = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_resp
// Purpose  : Self-checking bench for mem_resp. It runs a sequence of
//            directed steps followed by random accesses. Every access is
//            compared against a word-addressed memory model kept in the
//            bench, and against the expected handshake timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_resp;

    localparam int TB_ADDR_W = 10;
    localparam int TB_WAIT   = 2;
    localparam int RAM_WORDS = 1 << TB_ADDR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Memory model: only words written successfully are known.
    logic [31:0] model [int];
    // Expected rdata register contents, when known.
    logic        rd_known;
    logic [31:0] rd_val;

    mem_resp #(
        .ADDR_W      (TB_ADDR_W),
        .WAIT_CYCLES (TB_WAIT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ready  (ready),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete handshake. addr and wdata are changed to new values
    // right after acceptance. The request is held for 'hold' cycles into
    // DONE before it is dropped.
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [31:0] d, input logic [15:0] a_after,
                             input int hold);
        logic        fault;
        logic        chk_rd;
        logic [31:0] exp_rd;
        fault  = (rd && wr) || (int'(a) >= RAM_WORDS);
        chk_rd = 1'b0;
        exp_rd = 32'h0;
        if (fault) begin
            chk_rd = 1'b1;
        end else if (rd && model.exists(int'(a))) begin
            chk_rd = 1'b1;
            exp_rd = model[int'(a)];
        end

        @(negedge clk);
        check("idle_before_req", {31'b0, busy}, 32'd0);
        mem_rd = rd;
        mem_wr = wr;
        addr   = a;
        wdata  = d;
        @(posedge clk); #1;
        addr  = a_after;
        wdata = $urandom;
        check("busy_after_accept", {31'b0, busy}, 32'd1);

        for (int k = 1; k <= TB_WAIT + 1; k++) begin
            @(posedge clk); #1;
            if (k == TB_WAIT + 1) begin
                check("ready_latency", {31'b0, ready}, 32'd1);
            end else begin
                check("no_early_ready", {31'b0, ready}, 32'd0);
                check("err_without_ready", {31'b0, err}, 32'd0);
            end
        end
        check("err_at_ready", {31'b0, err}, {31'b0, fault});
        if (chk_rd) check("rdata_at_ready", rdata, exp_rd);

        if (!fault && wr) model[int'(a)] = d;
        if (chk_rd) begin
            rd_known = 1'b1;
            rd_val   = exp_rd;
        end else begin
            rd_known = 1'b0;
        end

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("held_no_ready", {31'b0, ready}, 32'd0);
            check("held_no_err", {31'b0, err}, 32'd0);
            check("held_busy", {31'b0, busy}, 32'd1);
            if (rd_known) check("held_rdata", rdata, rd_val);
        end
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        if (hold == 0) begin
            @(posedge clk); #1;
            check("done_busy", {31'b0, busy}, 32'd1);
            check("done_no_ready", {31'b0, ready}, 32'd0);
        end
        @(posedge clk); #1;
        check("back_idle", {31'b0, busy}, 32'd0);
        check("idle_no_ready", {31'b0, ready}, 32'd0);
        if (rd_known) check("idle_rdata", rdata, rd_val);
    endtask

    initial begin
        logic [31:0] v0;
        logic [31:0] v3;
        logic [31:0] v7;
        logic [15:0] ra;
        int          op;

        rst    = 1'b1;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        addr   = 16'h0;
        wdata  = 32'h0;
        rd_known = 1'b1;
        rd_val   = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_rdata", rdata, 32'h0);

        // Write then read back.
        do_access(1'b0, 1'b1, 16'h0005, 32'hDEADBEEF, 16'h0005, 0);
        do_access(1'b1, 1'b0, 16'h0005, 32'h0, 16'h0005, 0);

        // Out-of-range write faults and leaves word 0 untouched.
        v0 = $urandom;
        do_access(1'b0, 1'b1, 16'h0000, v0, 16'h0000, 0);
        do_access(1'b0, 1'b1, 16'h0400, 32'hCAFEF00D, 16'h0000, 0);
        do_access(1'b1, 1'b0, 16'h0000, 32'h0, 16'h0000, 1);

        // Read and write asserted together fault and leave word 3 untouched.
        v3 = $urandom;
        do_access(1'b0, 1'b1, 16'h0003, v3, 16'h0003, 0);
        do_access(1'b1, 1'b1, 16'h0003, 32'h55AA55AA, 16'h0003, 0);
        do_access(1'b1, 1'b0, 16'h0003, 32'h0, 16'h0003, 0);

        // Changing addr after acceptance does not redirect the read.
        do_access(1'b0, 1'b1, 16'h0010, 32'h00001010, 16'h0010, 0);
        do_access(1'b0, 1'b1, 16'h0011, 32'h00001111, 16'h0011, 0);
        do_access(1'b1, 1'b0, 16'h0010, 32'h0, 16'h0011, 0);

        // Request held in DONE is not accepted again.
        do_access(1'b1, 1'b0, 16'h0011, 32'h0, 16'h0011, 3);

        // Reset during the second wait cycle aborts the write.
        v7 = $urandom;
        do_access(1'b0, 1'b1, 16'h0007, v7, 16'h0007, 0);
        @(negedge clk);
        mem_wr = 1'b1;
        addr   = 16'h0007;
        wdata  = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst    = 1'b1;
        mem_wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ready", {31'b0, ready}, 32'd0);
        check("abort_rdata", rdata, 32'h0);
        rd_known = 1'b1;
        rd_val   = 32'h0;
        for (int i = 0; i < TB_WAIT + 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_ready", {31'b0, ready}, 32'd0);
        end
        do_access(1'b1, 1'b0, 16'h0007, 32'h0, 16'h0007, 0);

        // Random traffic over a small address window plus occasional faults.
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 9));
            ra = 16'($urandom_range(0, 15));
            if (op == 9) ra = 16'($urandom_range(RAM_WORDS, 16'hFFFF));
            if (op <= 3) begin
                do_access(1'b0, 1'b1, ra, $urandom, 16'($urandom), int'($urandom_range(0, 2)));
            end else if (op == 8) begin
                do_access(1'b1, 1'b1, ra, $urandom, 16'($urandom), int'($urandom_range(0, 2)));
            end else begin
                do_access(1'b1, 1'b0, ra, $urandom, 16'($urandom), int'($urandom_range(0, 2)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the internal RAM (depth 2^ADDR_W 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 1, extra wait cycles inserted before each access completes (0..15).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 mem_rd  input  1  read request from the initiator, held until ready is seen.
REQ-006 mem_wr  input  1  write request from the initiator, held until ready is seen.
REQ-007 addr  input  16  word address of the access.
REQ-008 wdata  input  32  write data, sampled with the request.
REQ-009 rdata  output  32  read data, valid from the ready cycle until the next accepted request.
REQ-010 ready  output  1  one-cycle completion pulse.
REQ-011 err  output  1  access fault flag, valid only while ready=1.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, RESP and DONE.
REQ-014 IDLE: if mem_rd or mem_wr is 1, SHALL latch addr, wdata and op type, load wait counter with WAIT_CYCLES and go to WAIT; otherwise stay.
REQ-015 WAIT: counter nonzero -> decrement and stay; counter zero -> perform the access at this edge and go to RESP.
REQ-016 Read access SHALL register RAM[addr] into rdata; write access SHALL commit wdata to RAM[addr] at the same edge.
REQ-017 RESP SHALL assert ready for exactly one cycle, then go to DONE unconditionally.
REQ-018 DONE SHALL hold ready=0 and rdata stable, returning to IDLE only on the first edge where mem_rd=0 and mem_wr=0 (4-phase handshake).
REQ-019 Latency: request sampled at edge N -> ready high in the cycle following edge N+WAIT_CYCLES+1.
REQ-020 Fault cases SHALL complete normally with err=1 in the RESP cycle: mem_rd and mem_wr both 1 at acceptance, or addr[15:ADDR_W] nonzero.
REQ-021 A faulted access SHALL leave the RAM unmodified and set rdata to 32'h0.
REQ-022 Changes on addr, wdata, mem_rd or mem_wr after acceptance SHALL NOT affect the in-flight access.
REQ-023 A request still asserted in DONE SHALL NOT be accepted as a new access.
REQ-024 err SHALL be 0 whenever ready=0.
REQ-025 A successful read SHALL drive rdata with the value; rdata SHALL otherwise be updated only by a completed access.
REQ-026 RAM contents are undefined at power-up and SHALL NOT be cleared by rst.

Reset
REQ-027 rst=1 SHALL force state IDLE, ready=0, err=0, rdata=0 and wait counter=0 at the next edge, in any state.
REQ-028 rst asserted in WAIT before the access edge SHALL abort the access with no RAM write.
REQ-029 rst SHALL take priority over every transition sampled at the same edge.

Verification
REQ-030 WAIT_CYCLES=1: write addr=0x0005, wdata=0xDEADBEEF, then drop mem_wr after ready, then read addr=0x0005 -> each ready 2 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-031 WAIT_CYCLES=0: back-to-back reads of addrs 1 and 2 with mem_rd dropped for 1 cycle between -> ready one cycle after each acceptance, no third ready while mem_rd was held high in DONE.
REQ-032 ADDR_W=10: write to addr=0x0400 -> ready with err=1, a following read of addr=0x0000 returns its prior contents, and rdata of the faulted access is 0x0.
REQ-033 mem_rd=mem_wr=1 at addr=0x0003 -> err=1 with ready, RAM[3] unchanged on readback.
REQ-034 WAIT_CYCLES=3: write 0x12345678 to addr 7, assert rst in the second WAIT cycle -> busy=0, ready never pulses, readback of addr 7 returns the old value.
REQ-035 Change addr from 0x0010 to 0x0011 one cycle after a read is accepted -> rdata=RAM[0x0010].
